// File: rtl/parity_rx_pkg.sv
// Shared state encoding, line-level and parity-mode constants for the parity serial receiver.
package parity_rx_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4,
        StBreak  = 3'd5
    } rx_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic PAR_EVEN  = 1'b0;

    // Parity bit the transmitter should have sent for a word whose XOR-reduction is data_xor.
    function automatic logic expected_parity(input logic data_xor, input logic mode);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/parity_rx_bit_timer.sv
// Bit-period timer for the receiver: half/full-bit sample ticks plus a data-bit counter.
module parity_rx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned BIT_W        = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_restart,
    input  logic             i_half,
    input  logic             i_bit_en,
    output logic             o_tick,
    output logic             o_last_bit,
    output logic [BIT_W-1:0] o_bit_idx
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [BIT_W-1:0] r_bit;
    logic [CNT_W-1:0] w_target;

    assign w_target   = i_half ? HALF_M1 : FULL_M1;
    assign o_tick     = !i_restart && (r_cnt == w_target);
    assign o_last_bit = (r_bit == LAST_BIT);
    assign o_bit_idx  = r_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_bit <= '0;
        end else if (i_restart) begin
            r_cnt <= '0;
            r_bit <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
            if (i_bit_en) begin
                r_bit <= r_bit + BIT_W'(1);
            end
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/parity_serial_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop; flags parity/stop errors.
// Define PARITY_RX_SYNC_EN to pass rx_in through a 2-flop synchroniser before any decision.
module parity_serial_rx #(
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned ODD_PARITY   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    import parity_rx_pkg::*;

    localparam int unsigned BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic        PAR_MODE = (ODD_PARITY != 0) ? PAR_ODD : PAR_EVEN;

    rx_state_e         r_state;
    rx_state_e         w_state_next;
    logic              w_rx;
    logic              w_tick;
    logic              w_last_bit;
    logic              w_restart;
    logic              w_half;
    logic              w_bit_en;
    logic [BIT_W-1:0]  w_bit_idx;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data_out;
    logic              r_par_err_pend;
    logic              r_stop_pend;
    logic              r_stop_bit;
    logic              r_data_valid;
    logic              r_par_err;
    logic              r_frame_err;

`ifdef PARITY_RX_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= LINE_IDLE;
            r_sync2 <= LINE_IDLE;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx = r_sync2;
`else
    assign w_rx = rx_in;
`endif

    parity_rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .DATA_W      (DATA_W),
        .BIT_W       (BIT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_restart),
        .i_half    (w_half),
        .i_bit_en  (w_bit_en),
        .o_tick    (w_tick),
        .o_last_bit(w_last_bit),
        .o_bit_idx (w_bit_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_restart    = 1'b0;
        w_half       = 1'b0;
        w_bit_en     = 1'b0;
        case (r_state)
            StIdle: begin
                w_restart = 1'b1;
                if (w_rx == START_BIT) w_state_next = StStart;
            end
            StStart: begin
                w_half = 1'b1;
                if (w_tick) w_state_next = (w_rx == START_BIT) ? StData : StIdle;
            end
            StData: begin
                w_bit_en = 1'b1;
                if (w_tick && w_last_bit) w_state_next = StParity;
            end
            StParity: begin
                if (w_tick) w_state_next = StStop;
            end
            StStop: begin
                // Leave at the stop midpoint so the next start edge can be caught early.
                if (w_tick) w_state_next = (w_rx == LINE_IDLE) ? StIdle : StBreak;
            end
            StBreak: begin
                w_restart = 1'b1;
                if (w_rx == LINE_IDLE) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Stop sample is staged one cycle so all results publish together with data_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift        <= '0;
            r_par_err_pend <= 1'b0;
            r_stop_pend    <= 1'b0;
            r_stop_bit     <= LINE_IDLE;
            r_data_out     <= '0;
            r_data_valid   <= 1'b0;
            r_par_err      <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_stop_pend  <= 1'b0;
            r_data_valid <= r_stop_pend;
            if (w_tick) begin
                case (r_state)
                    StData:   r_shift[w_bit_idx] <= w_rx;
                    StParity: r_par_err_pend <= (w_rx != expected_parity(^r_shift, PAR_MODE));
                    StStop: begin
                        r_stop_pend <= 1'b1;
                        r_stop_bit  <= w_rx;
                    end
                    default: ;
                endcase
            end
            if (r_stop_pend) begin
                r_data_out  <= r_shift;
                r_par_err   <= r_par_err_pend;
                r_frame_err <= (r_stop_bit != LINE_IDLE);
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign parity_err = r_par_err;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != StIdle);

endmodule
